mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Unified instruction/data memory slave for a multicycle core.
//                Accepts one read or write at a time, completes it after
//                WAIT_CYCLES wait states, and pulses ready for one cycle.
//                Read results land in an instruction register (fetches only)
//                and a data register (every read). A side load port preloads
//                words while the port is idle.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                a, wd                - request word address / write data
//                memread, memwrite    - request strobes (write wins if both)
//                irwrite              - marks a read as an instruction fetch
//                ld_en/ld_addr/ld_data- idle-time preload write port
//                instr, data          - registered read results
//                ready                - one-cycle completion pulse
//                busy                 - request outstanding (state != IDLE)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] wd,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              irwrite,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy
);

    localparam int         c_DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic                r_fetch;
    logic [DATA_W-1:0]   r_instr;
    logic [DATA_W-1:0]   r_data;
    logic                r_ready;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                w_ld_win;
    logic                w_access;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Preload only lands while idle; the access fires on the last WAIT cycle.
    assign w_ld_win = (r_state == S_IDLE) && ld_en;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // Single memory write port shared by preload and write requests. Reset
    // suppresses it so an aborted write never reaches the array.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        if (!reset) begin
            if (w_ld_win) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = ld_addr;
                w_mem_wdata = ld_data;
            end else if (w_access && r_we) begin
                w_mem_we    = 1'b1;
            end
        end
    end

    // The array is deliberately left out of reset so preloaded contents
    // survive a core reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_fetch <= 1'b0;
            r_instr <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A preload takes the cycle; the master must hold its request.
                    if (!ld_en && (memread || memwrite)) begin
                        r_addr  <= a;
                        r_wdata <= wd;
                        r_we    <= memwrite;
                        r_fetch <= irwrite & ~memwrite;
                        r_cnt   <= c_WAIT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            r_data <= r_mem[r_addr];
                            if (r_fetch) begin
                                r_instr <= r_mem[r_addr];
                            end
                        end
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign instr = r_instr;
    assign data  = r_data;
    assign ready = r_ready;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. A vector table of
//                read/write requests with hand-computed results, followed by
//                directed sequences for the multi-cycle corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int WAITC  = 2;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              memread;
    logic              memwrite;
    logic              irwrite;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAITC)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .wd       (wd),
        .memread  (memread),
        .memwrite (memwrite),
        .irwrite  (irwrite),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .instr    (instr),
        .data     (data),
        .ready    (ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic              rd;
        logic              ir;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdat;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] exp_instr;
    } vec_t;

    vec_t vecs [10];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        a        = '0;
        wd       = '0;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dv);
        ld_en   = 1'b1;
        ld_addr = ad;
        ld_data = dv;
        tick();
        ld_en   = 1'b0;
    endtask

    // Called just after the acceptance edge E0: checks busy/ready through
    // WAIT, the single ready pulse after edge E0+WAITC+1, and return to IDLE.
    task automatic finish_req(input string tag);
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        chk({tag, " ready_after_accept"}, 32'(ready), 32'd0);
        for (int k = 1; k <= WAITC; k++) begin
            tick();
            chk({tag, " ready_in_wait"}, 32'(ready), 32'd0);
            chk({tag, " busy_in_wait"}, 32'(busy), 32'd1);
        end
        tick();
        chk({tag, " ready_pulse"}, 32'(ready), 32'd1);
        tick();
        chk({tag, " ready_drop"}, 32'(ready), 32'd0);
        chk({tag, " busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic request(input string tag, input logic wr, input logic rd, input logic ir,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wdat);
        a        = ad;
        wd       = wdat;
        memwrite = wr;
        memread  = rd;
        irwrite  = ir;
        tick();
        clear_inputs();
        finish_req(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           wr    rd    ir    addr   wdat          exp_data      exp_instr
        vecs[0] = '{1'b0, 1'b1, 1'b1, 5'd3,  32'h0,        32'h20080005, 32'h20080005};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd7,  32'hDEADBEEF, 32'h20080005, 32'h20080005};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd7,  32'h0,        32'hDEADBEEF, 32'h20080005};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd9,  32'h00001234, 32'hDEADBEEF, 32'h20080005};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd9,  32'h0,        32'h00001234, 32'h20080005};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 5'd5,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd0,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd31, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 5'd31, 32'h0,        32'h00000001, 32'hFFFFFFFF};

        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset instr", instr, 32'h0);
        chk("reset data", data, 32'h0);

        preload(5'd3,  32'h20080005);
        preload(5'd4,  32'h11111111);
        preload(5'd5,  32'hA5A5A5A5);
        preload(5'd11, 32'h0B0B0B0B);
        preload(5'd12, 32'h0C0C0C0C);
        chk("preload busy", 32'(busy), 32'd0);

        // irwrite alone is not a request
        irwrite = 1'b1;
        tick();
        irwrite = 1'b0;
        chk("irwrite_only busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            request($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].ir,
                    vecs[i].addr, vecs[i].wdat);
            chk($sformatf("vec%0d data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d instr", i), instr, vecs[i].exp_instr);
        end

        // Inputs changing during WAIT/RESP are ignored; latched request completes.
        a = 5'd10; wd = 32'hCAFEF00D; memwrite = 1'b1;
        tick();
        a = 5'd11; wd = 32'h00000BAD; memwrite = 1'b1; memread = 1'b1;
        ld_en = 1'b1; ld_addr = 5'd12; ld_data = 32'h00000999;
        chk("ign busy_after_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= WAITC; k++) begin
            tick();
            chk("ign ready_in_wait", 32'(ready), 32'd0);
        end
        tick();
        chk("ign ready_pulse", 32'(ready), 32'd1);
        clear_inputs();
        tick();
        chk("ign ready_drop", 32'(ready), 32'd0);
        chk("ign busy_drop", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ign no_second_ready", 32'(ready), 32'd0);
        end
        request("rd10", 1'b0, 1'b1, 1'b0, 5'd10, 32'h0);
        chk("ign latched_write", data, 32'hCAFEF00D);
        request("rd11", 1'b0, 1'b1, 1'b0, 5'd11, 32'h0);
        chk("ign wait_write_dropped", data, 32'h0B0B0B0B);
        request("rd12", 1'b0, 1'b1, 1'b0, 5'd12, 32'h0);
        chk("ign wait_preload_dropped", data, 32'h0C0C0C0C);

        // Preload wins over a simultaneous request, which is then taken next edge.
        ld_en = 1'b1; ld_addr = 5'd13; ld_data = 32'h13131313;
        memread = 1'b1; a = 5'd13;
        tick();
        chk("ldreq busy_held_off", 32'(busy), 32'd0);
        ld_en = 1'b0;
        tick();
        clear_inputs();
        finish_req("ldreq");
        chk("ldreq data", data, 32'h13131313);
        chk("ldreq instr", instr, 32'hFFFFFFFF);

        // Reset in mid-WAIT of a write aborts it; memory keeps the old word.
        a = 5'd4; wd = 32'h44444444; memwrite = 1'b1;
        tick();
        clear_inputs();
        tick();
        chk("abort busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        chk("abort instr", instr, 32'h0);
        chk("abort data", data, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort no_ready", 32'(ready), 32'd0);
        end
        request("rd4", 1'b0, 1'b1, 1'b1, 5'd4, 32'h0);
        chk("abort old_data", data, 32'h11111111);
        chk("abort old_instr", instr, 32'h11111111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
